// File: rtl/vrased_reset_ctrl.sv
// VRASED violation-reset consumer: merges monitor requests into a timed MCU reset pulse,
// then waits for the reset-vector fetch (plus a guard window) before accepting new requests.
module vrased_reset_ctrl #(
   parameter int unsigned NUM_SRC       = 4,
   parameter int unsigned HOLD_CYCLES   = 8,
   parameter int unsigned GUARD_CYCLES  = 1,
   parameter int unsigned BOOT_TIMEOUT  = 1024,
   parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_SRC-1:0] viol_req_i,
   input  logic [15:0]        pc_i,
   input  logic               cause_clr_i,
   output logic               sys_rst_o,
   output logic               armed_o,
   output logic [NUM_SRC-1:0] cause_o,
   output logic               to_flag_o,
   output logic [7:0]         viol_count_o
);

   typedef enum logic [1:0] {
      StArmed    = 2'd0,
      StAssert   = 2'd1,
      StWaitBoot = 2'd2,
      StGuard    = 2'd3
   } state_e;

   localparam logic [7:0]  HoldInit  = 8'(HOLD_CYCLES - 1);
   localparam logic [3:0]  GuardInit = 4'(GUARD_CYCLES);
   localparam logic [15:0] BootLast  = 16'(BOOT_TIMEOUT - 1);

   state_e               state_q;
   logic                 sys_rst_q;
   logic                 armed_q;
   logic [NUM_SRC-1:0]   cause_q;
   logic                 to_flag_q;
   logic [7:0]           viol_count_q;
   logic [7:0]           hold_q;
   logic [15:0]          boot_q;
   logic [3:0]           guard_q;

   logic                 any_req;
   logic [7:0]           count_inc;

   assign any_req   = |viol_req_i;
   assign count_inc = (viol_count_q == 8'hFF) ? 8'hFF : viol_count_q + 8'd1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StWaitBoot;
         sys_rst_q    <= 1'b0;
         armed_q      <= 1'b0;
         cause_q      <= '0;
         to_flag_q    <= 1'b0;
         viol_count_q <= '0;
         hold_q       <= '0;
         boot_q       <= '0;
         guard_q      <= '0;
      end else begin
         case (state_q)
            StArmed: begin
               if (any_req) begin
                  state_q   <= StAssert;
                  sys_rst_q <= 1'b1;
                  armed_q   <= 1'b0;
                  hold_q    <= HoldInit;
                  // A request in the same cycle as a clear starts a fresh audit record.
                  if (cause_clr_i) begin
                     cause_q      <= viol_req_i;
                     viol_count_q <= 8'd1;
                     to_flag_q    <= 1'b0;
                  end else begin
                     cause_q      <= cause_q | viol_req_i;
                     viol_count_q <= count_inc;
                  end
               end else begin
                  sys_rst_q <= 1'b0;
                  armed_q   <= 1'b1;
                  if (cause_clr_i) begin
                     cause_q      <= '0;
                     to_flag_q    <= 1'b0;
                     viol_count_q <= '0;
                  end
               end
            end
            StAssert: begin
               armed_q <= 1'b0;
               cause_q <= cause_q | viol_req_i;
               if (hold_q == 8'd0) begin
                  state_q   <= StWaitBoot;
                  sys_rst_q <= 1'b0;
                  boot_q    <= '0;
               end else begin
                  sys_rst_q <= 1'b1;
                  hold_q    <= hold_q - 8'd1;
               end
            end
            StWaitBoot: begin
               // Monitors keep requesting until the vector fetch, so requests are ignored here.
               if (pc_i == RESET_HANDLER) begin
                  sys_rst_q <= 1'b0;
                  if (GUARD_CYCLES == 0) begin
                     state_q <= StArmed;
                     armed_q <= 1'b1;
                  end else begin
                     state_q <= StGuard;
                     armed_q <= 1'b0;
                     guard_q <= GuardInit;
                  end
               end else if (boot_q >= BootLast) begin
                  state_q   <= StAssert;
                  sys_rst_q <= 1'b1;
                  armed_q   <= 1'b0;
                  to_flag_q <= 1'b1;
                  hold_q    <= HoldInit;
               end else begin
                  sys_rst_q <= 1'b0;
                  armed_q   <= 1'b0;
                  boot_q    <= boot_q + 16'd1;
               end
            end
            StGuard: begin
               sys_rst_q <= 1'b0;
               if (guard_q <= 4'd1) begin
                  state_q <= StArmed;
                  armed_q <= 1'b1;
                  guard_q <= '0;
               end else begin
                  armed_q <= 1'b0;
                  guard_q <= guard_q - 4'd1;
               end
            end
            default: begin
               state_q   <= StWaitBoot;
               sys_rst_q <= 1'b1;
               armed_q   <= 1'b0;
               boot_q    <= '0;
            end
         endcase
      end
   end

   assign sys_rst_o    = sys_rst_q;
   assign armed_o      = armed_q;
   assign cause_o      = cause_q;
   assign to_flag_o    = to_flag_q;
   assign viol_count_o = viol_count_q;

endmodule
